mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port memory between the instruction-fetch port and the data (load/store) port of the RV32I pipeline. It lets the core run from a unified memory instead of separate instruction and data memories. It grants at most one request per cycle. It tracks outstanding reads in an in-order tag FIFO, routes each read response back to its owner, and discards fetch responses that a pipeline flush has made stale. Data accesses have priority, and a starvation counter guarantees that instruction fetch still makes forward progress.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one shared single-port memory
// Grants one access per cycle, tracks reads in an in-order tag FIFO, drops flushed fetch data.
module mem_arbiter #(
   parameter int MAX_OUTST    = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_flush,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        err_unexp
);

   localparam int CW = $clog2(MAX_OUTST) + 1;
   localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int SW = 4;

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [MAX_OUTST-1:0] src_q, src_d;
   logic [MAX_OUTST-1:0] drop_q, drop_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic                 err_q, err_d;

   logic head_src, head_drop, have_outst, pop, push, slot;
   logic d_elig, i_elig, fetch_pri, d_win, i_win;

   // Pointers wrap at MAX_OUTST, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      head_src   = src_q[rd_ptr_q];
      head_drop  = drop_q[rd_ptr_q];
      have_outst = (cnt_q != '0);
      pop        = m_rvalid && have_outst;
      slot       = (cnt_q < CW'(MAX_OUTST)) || m_rvalid;
      d_elig     = rst_n && d_req && m_ready && (d_we || slot);
      i_elig     = rst_n && i_req && m_ready && slot;
      fetch_pri  = (starve_q == SW'(STARVE_LIMIT));
      d_win      = d_elig && !(i_elig && fetch_pri);
      i_win      = i_elig && !d_win;
      push       = i_win || (d_win && !d_we);
   end

   always_comb begin
      i_gnt   = i_win;
      d_gnt   = d_win;
      m_req   = i_win || d_win;
      m_we    = 1'b0;
      m_be    = 4'h0;
      m_addr  = 32'h0;
      m_wdata = 32'h0;
      if (d_win) begin
         m_we    = d_we;
         m_be    = d_be;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else if (i_win) begin
         m_be    = 4'hF;
         m_addr  = i_addr;
      end
      i_rdata   = m_rdata;
      d_rdata   = m_rdata;
      d_rvalid  = pop && head_src;
      i_rvalid  = pop && !head_src && !head_drop && !i_flush;
      err_unexp = err_q;
   end

   always_comb begin
      src_d    = src_q;
      drop_d   = drop_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         src_d[wr_ptr_q]  = d_win;
         drop_d[wr_ptr_q] = 1'b0;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Marking free fetch slots too is harmless: a push always rewrites drop.
      if (i_flush) begin
         drop_d = drop_d | ~src_d;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      starve_d = starve_q;
      if (!i_req || i_win) begin
         starve_d = '0;
      end else if (d_win && (starve_q != SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + 1'b1;
      end

      err_d = err_q || (m_rvalid && !have_outst);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         src_q    <= '0;
         drop_q   <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         src_q    <= src_d;
         drop_q   <= drop_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter
// Outputs are compared each cycle against a queue-based model of the arbitration rules.
module tb_mem_arbiter;

   localparam int MAX = 3;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, i_flush, d_req, d_we, m_ready, m_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [3:0]  d_be;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, err_unexp;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [3:0]  m_be;

   int checks = 0;
   int errors = 0;

   // Model: each entry is {src, drop}; src 1 = data.
   logic [1:0] tq[$];
   int         m_starve;
   bit         m_err;

   logic obs_i_gnt, obs_d_gnt, obs_i_rvalid, obs_d_rvalid, obs_err;
   logic [31:0] obs_d_rdata;

   mem_arbiter #(.MAX_OUTST(MAX), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_idle();
      i_req = 0; i_flush = 0; d_req = 0; d_we = 0; m_ready = 1; m_rvalid = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; m_rdata = 0;
   endtask

   // Called just after a rising edge with inputs already driven.
   task automatic run_cycle();
      int n;
      bit slot, de, ie, ig, dg, eiv, edv;
      logic [1:0] head;
      logic [31:0] ea, ew;
      logic [3:0] eb;
      if (!rst_n) begin
         tq.delete();
         m_starve = 0;
         m_err = 0;
      end
      n = tq.size();
      slot = (n < MAX) || m_rvalid;
      de = rst_n && d_req && m_ready && (d_we || slot);
      ie = rst_n && i_req && m_ready && slot;
      if (de && ie) begin
         ig = (m_starve == LIM);
         dg = !ig;
      end else begin
         ig = ie;
         dg = de;
      end
      ea = dg ? d_addr : (ig ? i_addr : 32'h0);
      ew = dg ? d_wdata : 32'h0;
      eb = dg ? d_be : (ig ? 4'hF : 4'h0);
      eiv = 0; edv = 0;
      if (rst_n && m_rvalid && n > 0) begin
         head = tq[0];
         edv = head[1];
         eiv = !head[1] && !head[0] && !i_flush;
      end
      @(negedge clk);
      check("i_gnt", 32'(i_gnt), 32'(ig));
      check("d_gnt", 32'(d_gnt), 32'(dg));
      check("m_req", 32'(m_req), 32'(ig | dg));
      check("m_we", 32'(m_we), 32'(dg & d_we));
      check("m_be", 32'(m_be), 32'(eb));
      check("m_addr", m_addr, ea);
      check("m_wdata", m_wdata, ew);
      check("i_rvalid", 32'(i_rvalid), 32'(eiv));
      check("d_rvalid", 32'(d_rvalid), 32'(edv));
      check("i_rdata", i_rdata, m_rdata);
      check("d_rdata", d_rdata, m_rdata);
      check("err_unexp", 32'(err_unexp), 32'(m_err));
      check("cnt", 32'(dut.cnt_q), 32'(n));
      check("starve", 32'(dut.starve_q), 32'(m_starve));
      obs_i_gnt = i_gnt; obs_d_gnt = d_gnt; obs_i_rvalid = i_rvalid;
      obs_d_rvalid = d_rvalid; obs_err = err_unexp; obs_d_rdata = d_rdata;
      @(posedge clk);
      if (rst_n) begin
         if (m_rvalid) begin
            if (n > 0) void'(tq.pop_front());
            else m_err = 1;
         end
         if (ig) tq.push_back(2'b00);
         else if (dg && !d_we) tq.push_back(2'b10);
         if (i_flush) begin
            for (int k = 0; k < tq.size(); k++)
               if (!tq[k][1]) tq[k] = tq[k] | 2'b01;
         end
         if (!i_req || ig) m_starve = 0;
         else if (dg && m_starve < LIM) m_starve++;
      end
      #1;
   endtask

   task automatic drain();
      set_idle();
      for (int k = 0; k < 2 * MAX && tq.size() > 0; k++) begin
         m_rvalid = 1; m_rdata = $urandom;
         run_cycle();
      end
      set_idle();
   endtask

   initial begin
      rst_n = 0;
      set_idle();
      tq.delete(); m_starve = 0; m_err = 0;
      #1;
      run_cycle();
      run_cycle();
      rst_n = 1;

      // Load beats fetch, response routed to data port.
      i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h1234; d_be = 4'h3;
      run_cycle();
      check("dbf_d_gnt", 32'(obs_d_gnt), 32'd1);
      check("dbf_i_gnt", 32'(obs_i_gnt), 32'd0);
      set_idle();
      m_rvalid = 1; m_rdata = 32'hCAFE_0001;
      run_cycle();
      check("dbf_d_rvalid", 32'(obs_d_rvalid), 32'd1);
      check("dbf_d_rdata", obs_d_rdata, 32'hCAFE_0001);
      set_idle();

      // Stores keep winning until the starvation limit, then fetch wins.
      for (int k = 0; k <= LIM; k++) begin
         i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 1; d_be = 4'hF;
         d_addr = 32'h800 + 32'(k * 4); d_wdata = 32'(k);
         run_cycle();
         check("starve_i_gnt", 32'(obs_i_gnt), 32'(k == LIM));
      end
      check("starve_clear", 32'(dut.starve_q), 32'd0);
      drain();

      // FIFO full: reads blocked, store passes; a response frees a slot same-cycle.
      for (int k = 0; k < MAX; k++) begin
         i_req = 1; i_addr = 32'h300 + 32'(k * 4);
         run_cycle();
      end
      d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h900;
      run_cycle();
      check("full_i_gnt", 32'(obs_i_gnt), 32'd0);
      check("full_d_gnt", 32'(obs_d_gnt), 32'd1);
      set_idle();
      i_req = 1; i_addr = 32'h310; m_rvalid = 1; m_rdata = 32'h55;
      run_cycle();
      check("full_pop_i_gnt", 32'(obs_i_gnt), 32'd1);
      check("full_cnt_hold", 32'(dut.cnt_q), MAX);
      drain();

      // Flush makes in-flight fetches stale; the later load still returns.
      set_idle();
      i_req = 1; i_addr = 32'h100; run_cycle();
      i_addr = 32'h104; run_cycle();
      set_idle(); i_flush = 1; run_cycle();
      set_idle(); d_req = 1; d_addr = 32'hA00; d_be = 4'hF; run_cycle();
      set_idle();
      for (int k = 0; k < 3; k++) begin
         m_rvalid = 1; m_rdata = 32'h700 + 32'(k);
         run_cycle();
         check("flush_i_rvalid", 32'(obs_i_rvalid), 32'd0);
         check("flush_d_rvalid", 32'(obs_d_rvalid), 32'(k == 2));
      end
      set_idle();

      // Unexpected response is sticky until reset.
      m_rvalid = 1; m_rdata = 32'hBAD;
      run_cycle();
      check("unexp_i_rvalid", 32'(obs_i_rvalid), 32'd0);
      check("unexp_d_rvalid", 32'(obs_d_rvalid), 32'd0);
      set_idle();
      for (int k = 0; k < 3; k++) begin
         run_cycle();
         check("unexp_sticky", 32'(obs_err), 32'd1);
      end
      rst_n = 0;
      run_cycle();
      check("unexp_reset", 32'(obs_err), 32'd0);
      rst_n = 1;

      // Reset with three reads outstanding.
      i_req = 1; i_addr = 32'h20; run_cycle();
      set_idle(); d_req = 1; d_addr = 32'h24; d_be = 4'hF; run_cycle();
      set_idle(); i_req = 1; i_addr = 32'h28; run_cycle();
      i_req = 1; d_req = 1; m_rvalid = 1; rst_n = 0;
      run_cycle();
      check("rst_i_gnt", 32'(obs_i_gnt), 32'd0);
      check("rst_d_gnt", 32'(obs_d_gnt), 32'd0);
      check("rst_d_rvalid", 32'(obs_d_rvalid), 32'd0);
      check("rst_i_rvalid", 32'(obs_i_rvalid), 32'd0);
      rst_n = 1;
      set_idle();
      run_cycle();
      check("rst_cnt", 32'(dut.cnt_q), 32'd0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         rst_n   = ($urandom_range(0, 599) != 0);
         i_req   = ($urandom_range(0, 9) < 6);
         d_req   = ($urandom_range(0, 9) < 5);
         d_we    = $urandom_range(0, 1);
         i_flush = ($urandom_range(0, 9) == 0);
         m_ready = ($urandom_range(0, 9) < 8);
         m_rvalid = (tq.size() > 0) ? ($urandom_range(0, 1) == 1)
                                    : ($urandom_range(0, 99) < 2);
         i_addr  = $urandom; d_addr = $urandom; d_wdata = $urandom;
         d_be    = 4'($urandom); m_rdata = $urandom;
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
